// File: rtl/mul_fu_arbiter_if.sv
// mul_fu_arbiter_if
//   Bundles the requester handshakes, the shared result bus and the
//   multiplier FU connection of mul_fu_arbiter.
//   slave  : arbiter side (drives req_ready, resp_*, fu_*, busy)
//   master : environment side (drives req_valid/operands, resp_ready, fu_c)
interface mul_fu_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8,
  parameter int C_WIDTH = A_WIDTH + B_WIDTH
) ();
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*A_WIDTH-1:0] req_a;
  logic [NUM_REQ*B_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]         resp_valid;
  logic [NUM_REQ-1:0]         resp_ready;
  logic [C_WIDTH-1:0]         resp_c;
  logic                       fu_on_off;
  logic [A_WIDTH-1:0]         fu_a;
  logic [B_WIDTH-1:0]         fu_b;
  logic [C_WIDTH-1:0]         fu_c;
  logic                       busy;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready, fu_c,
    output req_ready, resp_valid, resp_c, fu_on_off, fu_a, fu_b, busy
  );

  modport master (
    output req_valid, req_a, req_b, resp_ready, fu_c,
    input  req_ready, resp_valid, resp_c, fu_on_off, fu_a, fu_b, busy
  );
endinterface

// File: rtl/mul_fu_arbiter.sv
// mul_fu_arbiter
//   Shares one fixed-latency multiplier FU among NUM_REQ requesters.
//   Round-robin grant, owner tags carried alongside the FU pipeline, and an
//   in-order result FIFO that returns each product to its owner.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : mul_fu_arbiter_if.slave (request, response and FU signals)
module mul_fu_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int A_WIDTH    = 8,
  parameter int B_WIDTH    = 8,
  parameter int C_WIDTH    = A_WIDTH + B_WIDTH,
  parameter int FU_LATENCY = 1,
  parameter int RES_DEPTH  = 2
) (
  input logic clk,
  input logic reset,
  mul_fu_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  // wide enough for occ + inflight (up to RES_DEPTH + FU_LATENCY)
  localparam int CW = $clog2(RES_DEPTH + FU_LATENCY + 2);

  logic [IW-1:0]         rr_q, rr_d;
  logic [FU_LATENCY-1:0] tag_vld_q;
  logic [IW-1:0]         tag_own_q [FU_LATENCY];
  logic [C_WIDTH-1:0]    fifo_c_q  [RES_DEPTH];
  logic [IW-1:0]         fifo_own_q[RES_DEPTH];
  logic [PW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         occ_q;

  logic [CW-1:0] infl;
  logic [IW-1:0] head_own, gnt, cand;
  logic          push, pop, can_issue, found, issue;
  int            idx;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(RES_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_own = fifo_own_q[rd_q];
  assign push     = tag_vld_q[FU_LATENCY-1];
  assign pop      = (occ_q != '0) && bus.resp_ready[head_own];

  always_comb begin
    infl = '0;
    for (int s = 0; s < FU_LATENCY; s++) infl = infl + CW'(tag_vld_q[s]);
  end

  // A same-cycle pop frees a slot, so it counts toward this cycle's issue.
  assign can_issue = (occ_q + infl - CW'(pop)) < CW'(RES_DEPTH);

  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IW'(idx);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
  end

  // No grants while reset is asserted so nothing is accepted and then lost.
  assign issue = found && can_issue && !reset;

  always_comb begin
    bus.req_ready = '0;
    bus.fu_on_off = 1'b0;
    bus.fu_a      = '0;
    bus.fu_b      = '0;
    rr_d          = rr_q;
    if (issue) begin
      bus.req_ready[gnt] = 1'b1;
      bus.fu_on_off      = 1'b1;
      bus.fu_a           = bus.req_a[int'(gnt)*A_WIDTH +: A_WIDTH];
      bus.fu_b           = bus.req_b[int'(gnt)*B_WIDTH +: B_WIDTH];
      rr_d               = (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
    end
  end

  always_comb begin
    bus.resp_valid = '0;
    if (occ_q != '0) bus.resp_valid[head_own] = 1'b1;
  end
  assign bus.resp_c = (occ_q != '0) ? fifo_c_q[rd_q] : '0;
  assign bus.busy   = (occ_q != '0) || (|tag_vld_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q      <= '0;
      tag_vld_q <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      occ_q     <= '0;
    end else begin
      rr_q         <= rr_d;
      tag_vld_q[0] <= issue;
      for (int s = 1; s < FU_LATENCY; s++) tag_vld_q[s] <= tag_vld_q[s-1];
      if (push) wr_q <= nxt(wr_q);
      if (pop)  rd_q <= nxt(rd_q);
      occ_q <= occ_q + CW'(push) - CW'(pop);
    end
  end

  // Payload storage needs no reset: it is qualified by tag_vld_q / occ_q.
  always_ff @(posedge clk) begin
    tag_own_q[0] <= gnt;
    for (int s = 1; s < FU_LATENCY; s++) tag_own_q[s] <= tag_own_q[s-1];
    if (push && !reset) begin
      fifo_c_q[wr_q]   <= bus.fu_c;
      fifo_own_q[wr_q] <= tag_own_q[FU_LATENCY-1];
    end
  end
endmodule

// File: doc/mul_fu_arbiter.md
# mul_fu_arbiter

Round-robin arbiter and sequencer that shares one multiplier functional unit among NUM_REQ requesters inside the s_tile. It accepts operand pairs over per-requester valid/ready handshakes and drives the FU's operand and enable inputs. It tracks each in-flight operation's owner through the fixed FU latency and returns each product to its owner through a small in-order result FIFO with backpressure.

## Interface
- NUM_REQ, default 4: number of requesters; must be ≥ 2.
- A_WIDTH, default 8: operand a width.
- B_WIDTH, default 8: operand b width.
- C_WIDTH, default A_WIDTH+B_WIDTH: product width.
- FU_LATENCY, default 1: cycles from FU operand/enable sample to `fu_c` valid.
- RES_DEPTH, default 2: result FIFO entries; must be ≥ 1.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_a  in  NUM_REQ*A_WIDTH  operand a; requester i occupies bits [i*A_WIDTH +: A_WIDTH].
- req_b  in  NUM_REQ*B_WIDTH  operand b, packed the same way.
- resp_valid  out  NUM_REQ  one-hot; names the owner of the FIFO head.
- resp_ready  in  NUM_REQ  per-requester result accept.
- resp_c  out  C_WIDTH  FIFO head product, shared by all requesters.
- fu_on_off  out  1  FU enable; high only in issue cycles.
- fu_a  out  A_WIDTH  operand a to the FU.
- fu_b  out  B_WIDTH  operand b to the FU.
- fu_c  in  C_WIDTH  FU product.
- busy  out  1  high when any operation is in flight or buffered.

## Operation
- **Issue condition:**
  - `can_issue = (occ + inflight - pop) < RES_DEPTH`.
  - `occ` is the FIFO occupancy, `inflight` is the count of issued results not yet captured, and `pop` is 1 when the head is accepted this cycle.
- **Arbitration:** when `can_issue` holds and any `req_valid` is high, grant the first valid requester at or after `rr_ptr`, searching cyclically.
  - Assert that requester's `req_ready` (combinational; it depends on `req_valid`).
  - Drive `fu_a`/`fu_b` from its operands and assert `fu_on_off`.
  - Set `rr_ptr` to (granted + 1) mod NUM_REQ.
- **No issue:** `fu_on_off`=0, `fu_a`=0, `fu_b`=0, all `req_ready`=0, and `rr_ptr` holds.
- **Tag pipeline:** a FU_LATENCY-deep shift register of {valid, owner index}. The issue cycle loads the head stage.
- **Capture:** when a valid tag reaches the last stage, `fu_c` is pushed with its owner into the FIFO in that same cycle. The issue condition guarantees the push never overflows.
- **Response:**
  - When the FIFO is non-empty, `resp_valid[owner]`=1 and `resp_c` shows the head product.
  - The head pops when `resp_ready[owner]` is high.
  - `resp_ready` bits of non-owners are ignored.
  - Results leave strictly in issue order.
- **Simultaneous push and pop:** both take effect and `occ` is unchanged. A pop on a full FIFO frees a slot for a same-cycle issue.
- **Widths:** the product is the full C_WIDTH unsigned product. The arbiter never truncates or sign-extends.
- **Reset** (any time, including mid-operation): discards all in-flight tags and FIFO contents. Sets `rr_ptr`=0 and `occ`=`inflight`=0. FU results that emerge after reset are not captured.

## Timing
- **Reset values:** `req_ready`=0, `resp_valid`=0, `resp_c`=0, `fu_on_off`=0, `fu_a`=0, `fu_b`=0, `busy`=0.
- **Latency:** issue in cycle t; push at the end of cycle t+FU_LATENCY; `resp_valid` high in cycle t+FU_LATENCY+1. With the defaults, a result appears 2 cycles after acceptance.
- **Throughput:** with RES_DEPTH ≥ FU_LATENCY+1 and `resp_ready` held high, one issue per cycle.
- **Backpressure:** with `resp_ready` low, at most RES_DEPTH issues are outstanding, then `req_ready` stays 0 until a pop.
- **Handshake rules:**
  - Requesters hold `req_valid` and operands stable until `req_ready`.
  - The arbiter holds `resp_valid` and `resp_c` stable until the pop.
- **Busy:** `busy` = (occ ≠ 0) or (inflight ≠ 0), driven from registered state.

## Test plan
- **Single request, defaults:**
  - Stimulus: requester 2 sends a=13, b=7 with `resp_ready`=all ones.
  - Response: `req_ready[2]` high in cycle 0; `fu_on_off`=1 with `fu_a`=13, `fu_b`=7; `resp_valid`=4'b0100 with `resp_c`=91 in cycle 2; `busy` low again in cycle 3.
- **Round-robin fairness:**
  - Stimulus: all four requesters hold `req_valid` continuously from reset.
  - Response: grants go 0,1,2,3,0,1 on consecutive cycles, one issue per cycle.
- **Pointer skip:**
  - Stimulus: only requesters 1 and 3 valid, with `rr_ptr`=2.
  - Response: grant order is 3,1,3,1.
- **Backpressure:**
  - Stimulus: `resp_ready`=0 with requester 0 streaming.
  - Response: exactly 2 accepts, then `req_ready` stays 0. After `resp_ready[0]` is raised, results pop in issue order and issue resumes in the same cycle as the first pop.
- **Max operands:**
  - Stimulus: a=255, b=255.
  - Response: `resp_c`=65025 (16'hFE01), no truncation.
- **Reset mid-operation:**
  - Stimulus: assert reset for one cycle with 1 op in flight and 1 buffered.
  - Response: the next cycle shows `resp_valid`=0 and `busy`=0 with no stale result ever returned, and the first post-reset grant goes to requester 0 when all requesters are valid.
